decoder_n_pipe: RTL and testbench
=================================

// Module: decoder_n_pipe
// PURPOSE
//  Parametrised N-to-2^N decoder with a registered, flow-controlled output.
//  Each accepted code is decoded per a per-beat MODE and queued in a 2-entry output buffer.
//  Valid/ready on both sides: full throughput, no combinational path from out_ready to in_ready.
//  Sits between a code-producing stage and select/enable fan-out logic.
// PARAMETERS
//  N     3          input code width; output width W = 2**N; legal range 1..8
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    synchronous reset, active-high
//  in_valid   in   1    X/mode valid this cycle
//  in_ready   out  1    block can accept a beat this cycle
//  X          in   N    code to decode
//  mode       in   2    00 one-hot, 01 thermometer, 10 inverted one-hot, 11 reserved
//  out_valid  out  1    Y/mode_err hold a decoded beat
//  out_ready  in   1    consumer takes the beat this cycle
//  Y          out  W    decoded vector
//  mode_err   out  1    beat was issued with mode 11 (per-beat sideband, not sticky)
// BEHAVIOUR
//  Decode, k = 0..W-1:
//   - 00: Y[k] = (k == X)
//   - 01: Y[k] = (k <= X); X=0 -> 1 bit set, X=W-1 -> all ones
//   - 10: Y[k] = ~(k == X)
//   - 11: decoded as 00; mode_err=1 travels with that beat
//  Handshake:
//   - push = in_valid & in_ready; pop = out_valid & out_ready
//   - in_ready = (cnt < 2), from registered cnt only; never depends on out_ready
//   - out_valid = (cnt != 0); Y/mode_err always show the head entry
//  Storage: 2 slots, head + tail, cnt in 0..2.
//   - push only: cnt+1; entry written to head if cnt==0, else tail
//   - pop only: cnt-1; tail moves to head
//   - push & pop, cnt==1: new entry to head, cnt stays 1
//   - cnt==2: in_ready=0, no push; pop frees a slot, in_ready=1 next cycle
//  Latency: beat accepted at edge t is on Y with out_valid=1 in cycle after t (1 cycle).
//  Stability: while out_valid & ~out_ready, Y and mode_err hold unchanged.
//  Ordering: strict FIFO; no beat dropped or duplicated.
//  X ignored when push=0. mode sampled per beat, no global mode state.
//  Reset, sampled at edge while rst=1:
//   - cnt=0, out_valid=0, Y=0, mode_err=0, both slots cleared
//   - in_ready=0 while rst=1; in_ready=1 first cycle after release
//   - mid-operation reset discards buffered beats; no pop completes in that cycle
// TESTING (N=3)
//  1) X=5, mode=00, out_ready=1 -> next cycle out_valid=1, Y=8'b0010_0000, mode_err=0
//  2) Sweep X=0..7 in mode 01 -> Y=8'h01,03,07,0F,1F,3F,7F,FF; mode 10, X=2 -> Y=8'hFB
//  3) out_ready=0, push X=1 then X=6 -> in_ready=0 after 2nd; Y=8'h02 held;
//     out_ready=1 -> Y=8'h02 then 8'h40
//  4) in_valid & out_ready=1 every cycle, X=0..7 -> one beat per cycle, in-order, cnt stays 1
//  5) X=3, mode=11 -> Y=8'h08, mode_err=1; next beat mode=00 -> mode_err=0
//  6) cnt=2, assert rst one cycle -> out_valid=0, Y=0; in_ready=0 during rst, 1 after

Source files
------------

// File: rtl/decoder_n_pipe.sv
// N-to-2^N decoder (one-hot / thermometer / inverted one-hot) with a 2-entry
// valid/ready output buffer; in_ready is derived from the registered occupancy only.
module decoder_n_pipe #(
  parameter int N = 3,
  localparam int W = 2 ** N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] X,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Y,
  output logic         mode_err
);

  logic [1:0]   cnt;
  logic [W-1:0] head_y, tail_y;
  logic         head_err, tail_err;
  logic         push, pop;
  logic [W-1:0] new_y;
  logic         new_err;

  // Reserved mode 11 decodes as one-hot; the error flag rides along with the beat.
  function automatic logic [W-1:0] decode(input logic [N-1:0] code, input logic [1:0] m);
    logic [W-1:0] d;
    d = '0;
    for (int k = 0; k < W; k++) begin
      case (m)
        2'b01:   d[k] = (k <= int'(code));
        2'b10:   d[k] = (k != int'(code));
        default: d[k] = (k == int'(code));
      endcase
    end
    return d;
  endfunction

  assign in_ready  = ~rst & (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign new_y     = decode(X, mode);
  assign new_err   = (mode == 2'b11);
  assign Y         = head_y;
  assign mode_err  = head_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 2'd0;
      head_y   <= '0;
      tail_y   <= '0;
      head_err <= 1'b0;
      tail_err <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            head_y   <= new_y;
            head_err <= new_err;
          end else begin
            tail_y   <= new_y;
            tail_err <= new_err;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head_y   <= tail_y;
          head_err <= tail_err;
          tail_y   <= '0;
          tail_err <= 1'b0;
          cnt      <= cnt - 2'd1;
        end
        // Simultaneous push and pop only happens at cnt==1: replace the head.
        2'b11: begin
          head_y   <= new_y;
          head_err <= new_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_n_pipe.sv
// Directed self-checking bench for decoder_n_pipe with N=3 (W=8).
module tb_decoder_n_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] X;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Y;
  logic       mode_err;

  int checks = 0;
  int errors = 0;

  decoder_n_pipe #(.N(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .X(X),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; X = 3'd0; mode = 2'b00;
    @(negedge clk); @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (Y !== 8'h00) begin errors++; $display("FAIL reset_y got=%h exp=00", Y); end
    checks++; if (mode_err !== 1'b0) begin errors++; $display("FAIL reset_mode_err got=%b exp=0", mode_err); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_onehot();
    out_ready = 1'b1; in_valid = 1'b1; X = 3'd5; mode = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL onehot_valid got=%b exp=1", out_valid); end
    checks++; if (Y !== 8'h20) begin errors++; $display("FAIL onehot_y got=%h exp=20", Y); end
    checks++; if (mode_err !== 1'b0) begin errors++; $display("FAIL onehot_err got=%b exp=0", mode_err); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL onehot_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_thermo();
    logic [7:0] th [8];
    th = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    out_ready = 1'b1; mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; X = 3'(i);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || Y !== th[i]) begin
        errors++; $display("FAIL thermo_x%0d got=%b/%h exp=1/%h", i, out_valid, Y, th[i]);
      end
      @(negedge clk);
    end
    in_valid = 1'b1; X = 3'd2; mode = 2'b10;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (Y !== 8'hFB) begin errors++; $display("FAIL inv_onehot_y got=%h exp=FB", Y); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; mode = 2'b00; in_valid = 1'b1; X = 3'd1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
    X = 3'd6;
    @(negedge clk);
    X = 3'd7;  // offered while full, must be refused
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
    checks++; if (Y !== 8'h02) begin errors++; $display("FAIL bp_head got=%h exp=02", Y); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || Y !== 8'h02) begin errors++; $display("FAIL bp_hold got=%b/%h exp=1/02", out_valid, Y); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (Y !== 8'h40 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_second got=%b/%h exp=1/40", out_valid, Y); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got=%b exp=1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_extra got=%b/%h exp=0", out_valid, Y); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_y;
    out_ready = 1'b1; mode = 2'b00; in_valid = 1'b1; X = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      exp_y = 8'h01 << (i - 1);
      checks++; if (out_valid !== 1'b1 || Y !== exp_y || in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_beat%0d got=%b/%h/%b exp=1/%h/1", i - 1, out_valid, Y, in_ready, exp_y);
      end
      if (i < 8) X = 3'(i);
      else in_valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_mode_err();
    out_ready = 1'b1; in_valid = 1'b1; X = 3'd3; mode = 2'b11;
    @(negedge clk);
    checks++; if (Y !== 8'h08 || mode_err !== 1'b1) begin errors++; $display("FAIL err_beat got=%h/%b exp=08/1", Y, mode_err); end
    mode = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (Y !== 8'h08 || mode_err !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL err_clear got=%h/%b/%b exp=08/0/1", Y, mode_err, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; mode = 2'b00; in_valid = 1'b1; X = 3'd4;
    @(negedge clk);
    X = 3'd2;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rm_full got=%b/%b exp=0/1", in_ready, out_valid); end
    rst = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_in_rst got=%b exp=0", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || Y !== 8'h00 || mode_err !== 1'b0) begin
      errors++; $display("FAIL rm_cleared got=%b/%h/%b exp=0/00/0", out_valid, Y, mode_err);
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_hold got=%b exp=0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_release got=%b exp=1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_discarded got=%b/%h exp=0", out_valid, Y); end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_thermo();
    test_backpressure();
    test_back_to_back();
    test_mode_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
